fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, setting the number of queue entries; legal values are powers of two, minimum 2.
REQ-002 The block SHALL have parameter ADDR_W, default 2, equal to log2(DEPTH).
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-low (0 = reset).
REQ-005 Port in_valid, input, 1 bit: the fetch stage presents a valid fetched word; tied high in the current core.
REQ-006 Port in_pc, input, 32 bits: PC of the presented word.
REQ-007 Port in_instruction, input, 32 bits: presented instruction word.
REQ-008 Port freeze, output, 1 bit: holds the fetch-stage PC register; drives the fetch stage's freeze input.
REQ-009 Port flush, input, 1 bit: taken-branch indication, shared with the fetch stage's Branch_token input.
REQ-010 Port out_valid, output, 1 bit: the head entry is available to decode.
REQ-011 Port out_ready, input, 1 bit: decode accepts the head entry this cycle.
REQ-012 Port out_pc, output, 32 bits: PC of the head entry.
REQ-013 Port out_instruction, output, 32 bits: instruction of the head entry.
REQ-014 Port count, output, ADDR_W+1 bits: number of occupied entries, 0..DEPTH.

Function
REQ-015 The block SHALL be a DEPTH-entry FIFO of {pc, instruction} pairs with read and write pointers of ADDR_W bits that wrap from DEPTH-1 to 0.
REQ-016 push SHALL equal in_valid & ~full & ~flush; pop SHALL equal out_valid & out_ready & ~flush.
REQ-017 full SHALL equal (count == DEPTH); empty SHALL equal (count == 0).
REQ-018 On push, the entry SHALL be written at the write pointer at the rising edge, and the write pointer SHALL increment.
REQ-019 On pop, the read pointer SHALL increment at the rising edge.
REQ-020 count SHALL increment on push-only, decrement on pop-only, and stay unchanged on simultaneous push and pop.
REQ-021 A word pushed at edge N SHALL appear on out_valid/out_pc/out_instruction in the cycle after edge N; there is no combinational path from input to output.
REQ-022 out_valid SHALL equal ~empty; out_pc and out_instruction SHALL show the entry at the read pointer when non-empty, and 32'h0 when empty.
REQ-023 freeze SHALL be combinational: full & ~flush & rst. While frozen, the fetch stage re-presents the same word, so no word is lost or duplicated.
REQ-024 When full with out_ready=1, the pop SHALL occur but no push in that cycle (freeze stays 1); the push occurs the next cycle.
REQ-025 flush SHALL have priority over push and pop: at the edge it SHALL clear count and both pointers to 0, and discard the word presented that cycle.
REQ-026 freeze SHALL be 0 while flush=1, so the fetch stage loads the branch address at that edge.
REQ-027 The block SHALL ignore out_ready while out_valid=0.
REQ-028 Output data SHALL stay stable while out_valid=1 and out_ready=0.

Reset
REQ-029 While rst=0 at a rising edge, the block SHALL set both pointers and count to 0; stored data need not be cleared.
REQ-030 During and after reset, outputs SHALL read out_valid=0, count=0, out_pc=0, out_instruction=0; freeze SHALL be 0 while rst=0.
REQ-031 Reset mid-operation SHALL discard all queued entries with no partial pop.

Verification
REQ-032 Fill: reset, then present pc 0,4,8,12,16 with out_ready=0 -> count reaches 4 after the 4th edge; freeze=1; pc 16 held and not written.
REQ-033 Drain order: from the full state of REQ-032, hold out_ready=1 -> out_pc sequence 0,4,8,12 on consecutive cycles, then 16 after its delayed push; no duplicates.
REQ-034 Streaming: out_ready=1 with continuous pushes of pc 0..28 -> each pc appears one cycle after its push; count stays at 1; freeze stays 0.
REQ-035 Flush: queue holds 3 entries, flush=1 while pc 12 is presented -> next cycle count=0, out_valid=0, freeze=0 during the flush cycle; the next word presented (pc 100) is pushed and appears the cycle after.
REQ-036 Wrap-around: perform 10 push/pop pairs with out_ready toggling -> pointers wrap past 3 and FIFO order is preserved.
REQ-037 Reset mid-operation: rst=0 for one edge with 2 entries queued -> out_valid=0, count=0, freeze=0; normal operation resumes on the next edge.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: decouples the fetch stage from decode with a small FIFO of
// {pc, instruction} pairs. Back-pressure to fetch is the combinational
// freeze output; a taken branch (flush) empties the queue in one edge.
module fetch_queue #(
  parameter int DEPTH  = 4,  // power of two, at least 2
  parameter int ADDR_W = 2   // log2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,             // synchronous, active-low
  input  logic              in_valid,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instruction,
  output logic              freeze,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instruction,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_STEP   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_STEP   = ADDR_W'(1);

  // Entry storage, indexed by the wrapping ADDR_W-bit pointers.
  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // A flush discards both the presented word and any pending pop.
  assign push = in_valid & ~full & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Freeze is released during a flush so fetch loads the branch target,
  // and held low in reset so fetch is not stalled by stale state.
  assign freeze = full & ~flush & rst;

  // Pointer and occupancy update; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_STEP;
      if (pop)  rd_ptr <= rd_ptr + PTR_STEP;
      unique case ({push, pop})
        2'b10:   count <= count + CNT_STEP;
        2'b01:   count <= count - CNT_STEP;
        default: count <= count;
      endcase
    end
  end

  // Entry write at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the data array has no reset; pointers and count alone decide
    // which entries are live, so clearing it would only cost logic.
    if (rst && push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instruction;
    end
  end

  // Head-of-queue presentation; zeros when nothing is queued.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    out_valid       = ~empty;
    out_pc          = 32'h0;
    out_instruction = 32'h0;
    if (!empty) begin
      out_pc          = pc_mem[rd_ptr];
      out_instruction = instr_mem[rd_ptr];
    end
  end

endmodule
